uart_rx_pkt_ctrl: RTL and testbench

//  Packet sequencer behind the UART receiver. Consumes the byte stream (data/valid/err).

---
 rtl/uart_rx_pkt_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet sequencer behind a UART receiver: sync hunt, length + XOR check, stream out.
// Optional inter-byte gap timeout enabled by defining UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 104170
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       pkt_ok,
  output logic       pkt_drop,
  output logic [1:0] drop_cause,
  output logic       rx_overrun
);

  localparam int IW    = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] C_FRAME = 2'd0;
  localparam logic [1:0] C_LEN   = 2'd1;
  localparam logic [1:0] C_CSUM  = 2'd2;
  localparam logic [1:0] C_TMO   = 2'd3;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_cfg
    $error("uart_rx_pkt_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    cause_d;
  logic          ok_d, drop_d, ovr_d;
  logic          wr_en;
  logic          active;
  logic          len_bad;
  logic          pay_done;
  logic          rd_last;
  logic          timeout_hit;

  logic [7:0] buf_mem [DEPTH];

  assign active   = (state_q == LEN) || (state_q == PAYLOAD) ||
                    (state_q == CSUM);
  assign len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign pay_done = 8'(wr_idx_q) == (len_q - 8'd1);
  assign rd_last  = 8'(rd_idx_q) == (len_q - 8'd1);

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] GAP_MAX = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] gap_q;

  assign timeout_hit = active && (gap_q == GAP_MAX);

  // Held at zero outside the receive states, so LEN always starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q <= '0;
    end else if (!active || rx_valid || timeout_hit) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    csum_d   = csum_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cause_d  = drop_cause;
    ok_d     = 1'b0;
    drop_d   = 1'b0;
    ovr_d    = 1'b0;
    wr_en    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = LEN;
        end
      end

      LEN: begin
        if (rx_err) begin
          drop_d  = 1'b1;
          cause_d = C_FRAME;
        end else if (rx_valid) begin
          if (len_bad) begin
            drop_d  = 1'b1;
            cause_d = C_LEN;
          end else begin
            len_d    = rx_data;
            csum_d   = rx_data;
            wr_idx_d = '0;
            state_d  = PAYLOAD;
          end
        end else if (timeout_hit) begin
          drop_d  = 1'b1;
          cause_d = C_TMO;
        end
      end

      PAYLOAD: begin
        if (rx_err) begin
          drop_d  = 1'b1;
          cause_d = C_FRAME;
        end else if (rx_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          csum_d   = csum_q ^ rx_data;
          if (pay_done) begin
            state_d = CSUM;
          end
        end else if (timeout_hit) begin
          drop_d  = 1'b1;
          cause_d = C_TMO;
        end
      end

      CSUM: begin
        if (rx_err) begin
          drop_d  = 1'b1;
          cause_d = C_FRAME;
        end else if (rx_valid) begin
          if (rx_data == csum_q) begin
            ok_d     = 1'b1;
            wr_idx_d = '0;
            csum_d   = '0;
            rd_idx_d = '0;
            state_d  = DRAIN;
          end else begin
            drop_d  = 1'b1;
            cause_d = C_CSUM;
          end
        end else if (timeout_hit) begin
          drop_d  = 1'b1;
          cause_d = C_TMO;
        end
      end

      DRAIN: begin
        ovr_d = rx_valid;
        if (pkt_ready) begin
          if (rd_last) begin
            rd_idx_d = '0;
            state_d  = HUNT;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // Every discard returns to hunting with a clean accumulator.
    if (drop_d) begin
      state_d  = HUNT;
      wr_idx_d = '0;
      csum_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      len_q      <= '0;
      csum_q     <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      pkt_ok     <= 1'b0;
      pkt_drop   <= 1'b0;
      drop_cause <= '0;
      rx_overrun <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      pkt_ok     <= ok_d;
      pkt_drop   <= drop_d;
      drop_cause <= cause_d;
      rx_overrun <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_idx_q[AW-1:0]] <= rx_data;
    end
  end

  assign pkt_valid = (state_q == DRAIN);
  assign pkt_data  = pkt_valid ? buf_mem[rd_idx_q[AW-1:0]] : 8'd0;
  assign pkt_last  = pkt_valid && rd_last;
  assign pkt_len   = pkt_valid ? len_q : 8'd0;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: packet-level model, random + directed frames.
// Honours UART_RX_PKT_TIMEOUT_EN for the gap-timeout scenario.
module tb_uart_rx_pkt_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 50;
  localparam int EV_OK   = 0;
  localparam int EV_DROP = 1;
  localparam int EV_OVR  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready = 1'b1;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       pkt_ok;
  logic       pkt_drop;
  logic [1:0] drop_cause;
  logic       rx_overrun;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [7:0] len;
  } exp_byte_t;

  typedef struct {
    int         kind;
    logic [1:0] cause;
  } exp_ev_t;

  exp_byte_t exp_b[$];
  exp_ev_t   exp_e[$];

  int vectors = 0;
  int miscompares = 0;

  logic rand_ready = 1'b0;
  logic ready_hold = 1'b1;

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_last  (pkt_last),
    .pkt_len   (pkt_len),
    .pkt_ok    (pkt_ok),
    .pkt_drop  (pkt_drop),
    .drop_cause(drop_cause),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Ready changes 2 time units after the edge, clear of stimulus at +1.
  always @(posedge clk) begin
    #2;
    pkt_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  function automatic void chk_ev(input int kind, input logic [1:0] cause);
    exp_ev_t x;
    vectors++;
    if (exp_e.size() == 0) begin
      miscompares++;
      $display("FAIL extra_event: got kind=%0d cause=%0d, need none",
               kind, cause);
    end else begin
      x = exp_e.pop_front();
      if (x.kind != kind || (kind == EV_DROP && x.cause != cause)) begin
        miscompares++;
        $display("FAIL event: got kind=%0d cause=%0d, need kind=%0d cause=%0d",
                 kind, cause, x.kind, x.cause);
      end
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents something.
  logic       prev_stall = 1'b0;
  logic [7:0] pv_d, pv_len;
  logic       pv_last;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (!pkt_valid || pkt_data !== pv_d || pkt_last !== pv_last ||
            pkt_len !== pv_len) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%0b d=%h l=%0b n=%0d, need v=1 d=%h l=%0b n=%0d",
                   pkt_valid, pkt_data, pkt_last, pkt_len, pv_d, pv_last, pv_len);
        end
      end
      if (pkt_valid && pkt_ready) begin
        vectors++;
        if (exp_b.size() == 0) begin
          miscompares++;
          $display("FAIL extra_byte: got d=%h, need no output", pkt_data);
        end else begin
          exp_byte_t e;
          e = exp_b.pop_front();
          if (pkt_data !== e.d || pkt_last !== e.last || pkt_len !== e.len) begin
            miscompares++;
            $display("FAIL out_byte: got d=%h l=%0b n=%0d, need d=%h l=%0b n=%0d",
                     pkt_data, pkt_last, pkt_len, e.d, e.last, e.len);
          end
        end
      end
      prev_stall = pkt_valid && !pkt_ready;
      pv_d = pkt_data;
      pv_last = pkt_last;
      pv_len = pkt_len;
      if (pkt_ok) chk_ev(EV_OK, 2'd0);
      if (pkt_drop) chk_ev(EV_DROP, drop_cause);
      if (rx_overrun) chk_ev(EV_OVR, 2'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int kind, input logic [1:0] cause);
    exp_ev_t x;
    x.kind = kind;
    x.cause = cause;
    exp_e.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    tick($urandom_range(0, gmax));
    rx_data = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_err(input logic with_valid);
    rx_err = 1'b1;
    rx_valid = with_valid;
    tick(1);
    rx_err = 1'b0;
    rx_valid = 1'b0;
  endtask

  // Reference: checksum is the XOR of the length byte and every payload byte.
  task automatic send_pkt(input logic [7:0] pl[$], input bit bad, input int gmax);
    logic [7:0] len, cs;
    exp_byte_t e;
    len = 8'(pl.size());
    cs = len;
    foreach (pl[i]) cs ^= pl[i];
    send_byte(8'hA5, gmax);
    send_byte(len, gmax);
    foreach (pl[i]) send_byte(pl[i], gmax);
    if (bad) begin
      push_ev(EV_DROP, 2'd2);
      send_byte(cs ^ 8'($urandom_range(1, 255)), gmax);
    end else begin
      push_ev(EV_OK, 2'd0);
      foreach (pl[i]) begin
        e.d = pl[i];
        e.last = (i == pl.size() - 1);
        e.len = len;
        exp_b.push_back(e);
      end
      send_byte(cs, gmax);
    end
  endtask

  task automatic check_drained(input string nm);
    int n = 0;
    while ((exp_b.size() != 0 || pkt_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    tick(3);
    vectors++;
    if (n >= 3000 || exp_b.size() != 0 || exp_e.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d bytes %0d events pending (wait %0d), need 0 0",
               nm, exp_b.size(), exp_e.size(), n);
      exp_b.delete();
      exp_e.delete();
    end
  endtask

  task automatic check_zero(input string nm);
    vectors++;
    if ({pkt_valid, pkt_last, pkt_ok, pkt_drop, rx_overrun} !== 5'b0 ||
        pkt_data !== 8'd0 || pkt_len !== 8'd0 || drop_cause !== 2'd0) begin
      miscompares++;
      $display("FAIL %s: got v=%0b l=%0b ok=%0b dr=%0b ov=%0b d=%h n=%0d c=%0d, need all 0",
               nm, pkt_valid, pkt_last, pkt_ok, pkt_drop, rx_overrun,
               pkt_data, pkt_len, drop_cause);
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    int kind, len, k;
    logic [7:0] b;

    tick(3);
    check_zero("reset_state");
    reset_n = 1'b1;
    tick(2);

    send_byte(8'h55, 0);
    send_byte(8'hFF, 0);
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(pl, 1'b0, 0);
    check_drained("basic_pkt");

    send_pkt(pl, 1'b0, 0);
    tick(1);
    ready_hold = 1'b0;
    tick(5);
    ready_hold = 1'b1;
    check_drained("stall_pkt");

    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    push_ev(EV_DROP, 2'd2);
    send_byte(8'h31, 0);
    check_drained("bad_csum");
    pl = '{8'h10, 8'h20};
    send_pkt(pl, 1'b0, 1);
    check_drained("after_bad_csum");

    send_byte(8'hA5, 0);
    push_ev(EV_DROP, 2'd1);
    send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    push_ev(EV_DROP, 2'd1);
    send_byte(8'h11, 0);
    check_drained("bad_len");

    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    push_ev(EV_DROP, 2'd0);
    send_err(1'b1);
    check_drained("frame_err");

    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset_n = 1'b0;
    #2;
    check_zero("reset_mid_payload");
    tick(2);
    reset_n = 1'b1;
    tick(1);
    pl = '{8'hDE, 8'hAD};
    send_pkt(pl, 1'b0, 0);
    check_drained("after_reset");

    ready_hold = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03};
    send_pkt(pl, 1'b0, 0);
    tick(1);
    push_ev(EV_OVR, 2'd0);
    send_byte(8'hA5, 0);
    tick(2);
    ready_hold = 1'b1;
    check_drained("overrun");
    pl = '{8'h77};
    send_pkt(pl, 1'b0, 0);
    check_drained("after_overrun");

`ifdef UART_RX_PKT_TIMEOUT_EN
    send_byte(8'hA5, 0);
    push_ev(EV_DROP, 2'd3);
    send_byte(8'h02, 0);
    tick(60);
    check_drained("timeout_drop");
`else
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    tick(60);
    check_drained("no_timeout");
    push_ev(EV_OK, 2'd0);
    exp_b.push_back('{8'h10, 1'b0, 8'h02});
    exp_b.push_back('{8'h20, 1'b1, 8'h02});
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h32, 0);
    check_drained("late_completion");
`endif

    rand_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, MAX_LEN);
      pl.delete();
      for (int j = 0; j < len; j++) pl.push_back(8'($urandom));
      if (kind <= 5) begin
        send_pkt(pl, 1'b0, 2);
      end else if (kind == 6) begin
        send_pkt(pl, 1'b1, 2);
      end else if (kind == 7) begin
        send_byte(8'hA5, 2);
        push_ev(EV_DROP, 2'd1);
        b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        send_byte(b, 2);
      end else if (kind == 8) begin
        send_byte(8'hA5, 2);
        send_byte(8'(len), 2);
        k = $urandom_range(0, len);
        for (int j = 0; j < k; j++) send_byte(pl[j], 2);
        push_ev(EV_DROP, 2'd0);
        send_err(1'($urandom_range(0, 1)));
      end else begin
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          send_byte(b, 1);
        end
      end
      check_drained("random");
    end
    rand_ready = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
